// File: rtl/collision_monitor.sv
// Game supervisor: watches the bird column of the LED layers and raises death on overlap or loss.
// Tracks pipes cleared as a saturating score; all outputs are registered, 1-cycle reaction.
module collision_monitor #(
   parameter int ROWS     = 8,
   parameter int COLS     = 8,
   parameter int BIRD_COL = 6,
   parameter int SCORE_W  = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          restart,
   input  logic                          frame_tick,
   input  logic [ROWS-1:0][COLS-1:0]     red_array,
   input  logic [ROWS-1:0][COLS-1:0]     green_array,
   output logic                          dead,
   output logic                          playing,
   output logic [$clog2(ROWS)-1:0]       hit_row,
   output logic [SCORE_W-1:0]            score
);

   localparam int RW = $clog2(ROWS);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [1:0] {IDLE, PLAY, DEAD} state_t;

   state_t             state, state_nx;
   logic [SCORE_W-1:0] score_nx;
   logic [RW-1:0]      hit_row_nx;
   logic               pipe_prev, pipe_prev_nx;

   logic [ROWS-1:0]    bird_col;
   logic [ROWS-1:0]    pipe_col;
   logic [ROWS-1:0]    overlap;
   logic               hit;
   logic               lost;
   logic               pipe_now;
   logic [RW-1:0]      hit_idx;

   always_comb begin
      bird_col = '0;
      pipe_col = '0;
      for (int r = 0; r < ROWS; r++) begin
         bird_col[r] = red_array[r][BIRD_COL];
         pipe_col[r] = green_array[r][BIRD_COL];
      end
   end

   assign overlap  = bird_col & pipe_col;
   assign hit      = |overlap;
   assign lost     = ~|bird_col;
   assign pipe_now = |pipe_col;

   // Scan downward so the lowest overlapping row wins.
   always_comb begin
      hit_idx = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (overlap[r]) hit_idx = RW'(r);
      end
   end

   always_comb begin
      state_nx     = state;
      score_nx     = score;
      hit_row_nx   = hit_row;
      pipe_prev_nx = pipe_prev;
      if (restart) begin
         state_nx     = IDLE;
         pipe_prev_nx = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nx     = PLAY;
                  score_nx     = '0;
                  hit_row_nx   = '0;
                  pipe_prev_nx = 1'b0;
               end
            end
            PLAY: begin
               // Death outranks a scoring tick in the same cycle.
               if (hit || lost) begin
                  state_nx   = DEAD;
                  hit_row_nx = hit ? hit_idx : RW'(ROWS - 1);
               end else if (frame_tick) begin
                  pipe_prev_nx = pipe_now;
                  if (pipe_prev && !pipe_now && (score != SCORE_MAX))
                     score_nx = score + 1'b1;
               end
            end
            DEAD: ;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         score     <= '0;
         hit_row   <= '0;
         pipe_prev <= 1'b0;
         dead      <= 1'b0;
         playing   <= 1'b0;
      end else begin
         state     <= state_nx;
         score     <= score_nx;
         hit_row   <= hit_row_nx;
         pipe_prev <= pipe_prev_nx;
         dead      <= (state_nx == DEAD);
         playing   <= (state_nx == PLAY);
      end
   end

endmodule

// File: doc/collision_monitor.md
COLLISION_MONITOR -- requirements
Module: collision_monitor

Interface
REQ-001 Parameter ROWS, default 8: LED matrix row count, index 0..ROWS-1.
REQ-002 Parameter COLS, default 8: LED matrix column count, index 0..COLS-1.
REQ-003 Parameter BIRD_COL, default 6: column checked for bird/pipe overlap; SHALL satisfy 0 <= BIRD_COL < COLS.
REQ-004 Parameter SCORE_W, default 8: score counter width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state rising-edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 start  input  1  one-cycle pulse; begins a game from IDLE.
REQ-009 restart  input  1  one-cycle pulse; forces return to IDLE from any state.
REQ-010 frame_tick  input  1  one-cycle pulse; pipes advanced one column this cycle.
REQ-011 red_array  input  [ROWS-1:0][COLS-1:0]  bird layer; element [r][c] is row r, column c.
REQ-012 green_array  input  [ROWS-1:0][COLS-1:0]  pipe layer, same indexing.
REQ-013 dead  output  1  high while in DEAD state.
REQ-014 playing  output  1  high while in PLAY state.
REQ-015 hit_row  output  $clog2(ROWS)  lowest row index of the overlap that caused death.
REQ-016 score  output  SCORE_W  pipes cleared in the current game.

Function
REQ-017 States: IDLE, PLAY, DEAD; outputs are registered; dead = (state==DEAD), playing = (state==PLAY).
REQ-018 IDLE -> PLAY on start; on this transition, score and hit_row are cleared to 0.
REQ-019 In PLAY, hit = OR over r of (red_array[r][BIRD_COL] & green_array[r][BIRD_COL]).
REQ-020 In PLAY, lost = no red_array[r][BIRD_COL] set (bird left the screen).
REQ-021 PLAY -> DEAD on the clock edge where hit or lost is sampled high; dead rises exactly 1 cycle after the inputs show the event.
REQ-022 On a hit, hit_row loads the lowest r with an overlap; on lost without hit, hit_row loads ROWS-1.
REQ-023 DEAD is sticky: dead, hit_row and score hold until restart or reset; start, frame_tick and array changes are ignored.
REQ-024 Pipe tracking: register pipe_prev = OR over r of green_array[r][BIRD_COL], updated only on frame_tick in PLAY.
REQ-025 Score: on frame_tick in PLAY, if pipe_prev=1 and the current BIRD_COL pipe OR = 0, then score increments by 1.
REQ-026 Score saturates at 2^SCORE_W-1 and does not wrap.
REQ-027 Same-cycle hit/lost and scoring frame_tick: go to DEAD; score SHALL NOT increment.
REQ-028 restart takes priority over every other input in every state: next state IDLE, score and hit_row hold their last values, pipe_prev clears.
REQ-029 start and restart in the same cycle in IDLE: stay in IDLE.
REQ-030 start outside IDLE is ignored.
REQ-031 Columns other than BIRD_COL never affect any output.

Reset
REQ-032 While reset is high: state=IDLE, dead=0, playing=0, hit_row=0, score=0, pipe_prev=0, all asynchronously.
REQ-033 Reset asserted mid-game, including in the same cycle as a hit, yields the REQ-032 values; no DEAD is entered.
REQ-034 After reset deasserts, the first action is start; no game resumes without it.

Verification (defaults ROWS=COLS=8, BIRD_COL=6)
REQ-035 Overlap: start; red[3][6]=1 with green[3][6]=0 for 5 cycles -> dead=0, playing=1; then green[3][6]=1 -> dead=1 one cycle later, hit_row=3.
REQ-036 Multi-row and off-column: red[5][6]=red[2][6]=green[5][6]=green[2][6]=1 -> hit_row=2; red[4][5]&green[4][5] only -> dead stays 0.
REQ-037 Lost and sticky: red column 6 all zeros in PLAY -> dead=1, hit_row=7; later start pulses and cleared arrays -> dead stays 1 until restart.
REQ-038 Scoring: pipe at column 6 for 2 ticks, then column clear on a tick, repeated 3 times with no overlap -> score=3.
REQ-039 Saturation and priority: SCORE_W=2, 4 pipes cleared -> score=3. Hit with a scoring tick in the same cycle -> dead=1 with score unchanged. restart with a hit in the same cycle -> IDLE, dead=0.
REQ-040 Async reset: assert reset between clock edges during PLAY with score=2 -> all outputs 0 immediately; start afterward -> PLAY with score=0.
